// File: rtl/prog_clock_divider.sv
// Programmable clock divider: divides clock_in by a loadable period with a loadable
// high-phase length. New settings are staged and only take effect at period boundaries.
module prog_clock_divider #(
  parameter int WIDTH       = 28,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] div_value,
  input  logic [WIDTH-1:0] duty_value,
  output logic             clock_out,
  output logic             tick,
  output logic             running,
  output logic             pending,
  output logic             load_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_HIGH = DEF_DIV >> 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_act_div;
  logic [WIDTH-1:0] r_act_high;
  logic [WIDTH-1:0] r_pend_div;
  logic [WIDTH-1:0] r_pend_high;
  logic             r_clock_out;
  logic             r_tick;
  logic             r_pending;
  logic             r_load_err;

  logic             w_active;
  logic             w_boundary;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_apply;
  logic [WIDTH-1:0] w_new_high;

  assign w_active   = (r_state != S_IDLE);
  assign w_boundary = w_active && (r_cnt == r_act_div - ONE);
  assign w_load_ok  = load && (div_value >= TWO);
  assign w_load_bad = load && (div_value < TWO);
  // Staged setting is promoted at the end of a period, or immediately when idle.
  assign w_apply    = r_pending && (w_boundary || !w_active);

  // High-phase length always lands in 1..div-1 for any accepted divisor.
  always_comb begin
    w_new_high = div_value >> 1;
    if (duty_value == '0) begin
      w_new_high = div_value >> 1;
    end else if (duty_value >= div_value) begin
      w_new_high = div_value - ONE;
    end else begin
      w_new_high = duty_value;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_act_div   <= DEF_DIV;
      r_act_high  <= DEF_HIGH;
      r_pend_div  <= DEF_DIV;
      r_pend_high <= DEF_HIGH;
      r_clock_out <= 1'b0;
      r_tick      <= 1'b0;
      r_pending   <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_load_err <= w_load_bad;

      if (w_apply) begin
        r_act_div  <= r_pend_div;
        r_act_high <= r_pend_high;
      end

      // A load in the same cycle as a promotion re-arms pending with the new value.
      if (w_load_ok) begin
        r_pend_div  <= div_value;
        r_pend_high <= w_new_high;
        r_pending   <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt       <= '0;
          r_clock_out <= 1'b0;
          r_tick      <= 1'b0;
          if (enable) r_state <= S_RUN;
        end
        default: begin
          r_clock_out <= (r_cnt < r_act_high);
          r_tick      <= (r_cnt == '0);
          r_cnt       <= w_boundary ? '0 : r_cnt + ONE;
          if (enable) begin
            r_state <= S_RUN;
          end else if (w_boundary) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_STOPPING;
          end
        end
      endcase
    end
  end

  assign clock_out = r_clock_out;
  assign tick      = r_tick;
  assign running   = w_active;
  assign pending   = r_pending;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: a vector table for the steady-state patterns
// plus hand-written sequences for boundary loads, stop/resume and mid-period reset.
module tb_prog_clock_divider;
  localparam int W = 28;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         load;
  logic [W-1:0] div_value;
  logic [W-1:0] duty_value;
  logic         clock_out;
  logic         tick;
  logic         running;
  logic         pending;
  logic         load_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         en;
    logic         ld;
    logic [W-1:0] dv;
    logic [W-1:0] du;
    logic [4:0]   exp;  // {clock_out, tick, running, pending, load_err}
  } vec_t;

  vec_t vecs[$];

  prog_clock_divider #(.WIDTH(W), .DEFAULT_DIV(2)) dut (
    .clock_in  (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .div_value (div_value),
    .duty_value(duty_value),
    .clock_out (clock_out),
    .tick      (tick),
    .running   (running),
    .pending   (pending),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {clock_out, tick, running, pending, load_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic en, input logic ld, input logic [W-1:0] dv,
                         input logic [W-1:0] du, input logic [4:0] exp);
    vec_t v;
    v.en = en; v.ld = ld; v.dv = dv; v.du = du; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic step(input logic en, input logic ld, input logic [W-1:0] dv,
                      input logic [W-1:0] du);
    enable     = en;
    load       = ld;
    div_value  = dv;
    duty_value = du;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 999;
    for (int k = 1; k <= 64; k++) begin
      step(enable, 1'b0, '0, '0);
      if (tick) begin
        n = k;
        break;
      end
    end
  endtask

  // Assumes the current sample is a tick; counts the period and its high cycles.
  task automatic measure_period(output int per, output int hi);
    logic found;
    found = 1'b0;
    per = 1;
    hi  = clock_out ? 1 : 0;
    for (int k = 0; k < 64; k++) begin
      step(enable, 1'b0, '0, '0);
      if (tick) begin
        found = 1'b1;
        break;
      end
      per++;
      if (clock_out) hi++;
    end
    if (!found) per = 999;
  endtask

  initial begin
    int n;
    int per;
    int hi;

    // defaults (div 2): toggle every cycle
    add_vec(1, 0, 0, 0, 5'b00100);
    add_vec(1, 0, 0, 0, 5'b11100);
    add_vec(1, 0, 0, 0, 5'b00100);
    add_vec(1, 0, 0, 0, 5'b11100);
    // load div 5 in a boundary cycle; applied at the following boundary
    add_vec(1, 1, 5, 0, 5'b00110);
    add_vec(1, 0, 0, 0, 5'b11110);
    add_vec(1, 0, 0, 0, 5'b00100);
    for (int p = 0; p < 2; p++) begin
      add_vec(1, 0, 0, 0, 5'b11100);
      add_vec(1, 0, 0, 0, 5'b10100);
      add_vec(1, 0, 0, 0, 5'b00100);
      add_vec(1, 0, 0, 0, 5'b00100);
      add_vec(1, 0, 0, 0, 5'b00100);
    end
    // div 8, duty 9 clamps to 7 high
    add_vec(1, 1, 8, 9, 5'b11110);
    add_vec(1, 0, 0, 0, 5'b10110);
    add_vec(1, 0, 0, 0, 5'b00110);
    add_vec(1, 0, 0, 0, 5'b00110);
    add_vec(1, 0, 0, 0, 5'b00100);
    add_vec(1, 0, 0, 0, 5'b11100);
    add_vec(1, 1, 1, 0, 5'b10101);  // rejected load
    for (int k = 0; k < 5; k++) add_vec(1, 0, 0, 0, 5'b10100);
    add_vec(1, 0, 0, 0, 5'b00100);
    add_vec(1, 0, 0, 0, 5'b11100);
    for (int k = 0; k < 6; k++) add_vec(1, 0, 0, 0, 5'b10100);
    add_vec(1, 0, 0, 0, 5'b00100);
    // div 6 duty 4, then enable drops at cnt 2
    add_vec(1, 1, 6, 4, 5'b11110);
    for (int k = 0; k < 6; k++) add_vec(1, 0, 0, 0, 5'b10110);
    add_vec(1, 0, 0, 0, 5'b00100);
    add_vec(1, 0, 0, 0, 5'b11100);
    add_vec(1, 0, 0, 0, 5'b10100);
    add_vec(0, 0, 0, 0, 5'b10100);
    add_vec(0, 0, 0, 0, 5'b10100);
    add_vec(0, 0, 0, 0, 5'b00100);
    add_vec(0, 0, 0, 0, 5'b00000);
    add_vec(0, 0, 0, 0, 5'b00000);
    add_vec(0, 0, 0, 0, 5'b00000);

    reset      = 1'b1;
    enable     = 1'b0;
    load       = 1'b0;
    div_value  = '0;
    duty_value = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(obs()), 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].ld, vecs[i].dv, vecs[i].du);
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
    end

    // load in boundary, overwritten two cycles later: old period, then 10
    step(1, 0, 0, 0);
    check("restart_entry", 32'(obs()), 32'b00100);
    repeat (5) step(1, 0, 0, 0);
    step(1, 1, 4, 0);
    check("boundary_load_pending", 32'(pending), 32'h1);
    step(1, 0, 0, 0);
    check("old_period_tick", 32'(tick), 32'h1);
    step(1, 1, 10, 0);
    wait_tick(n);
    check("old_period_len", 32'(n), 32'd5);
    check("pending_cleared", 32'(pending), 32'h0);
    measure_period(per, hi);
    check("div10_period", 32'(per), 32'd10);
    check("div10_high", 32'(hi), 32'd5);

    // brief enable drop mid-period resumes with no break in the count
    step(0, 0, 0, 0);
    check("stopping_running_a", 32'(running), 32'h1);
    step(0, 0, 0, 0);
    check("stopping_running_b", 32'(running), 32'h1);
    step(1, 0, 0, 0);
    check("resume_running", 32'(running), 32'h1);
    wait_tick(n);
    check("resume_tick_gap", 32'(n), 32'd7);

    // reset mid high phase with a pending setting
    step(1, 1, 3, 0);
    check("pre_reset_pending", 32'(pending), 32'h1);
    step(1, 0, 0, 0);
    check("pre_reset_high", 32'(clock_out), 32'h1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'(obs()), 32'h0);
    #2;
    reset = 1'b0;
    step(1, 0, 0, 0);
    check("post_reset_entry", 32'(obs()), 32'b00100);
    wait_tick(n);
    check("post_reset_first_tick", 32'(n), 32'd1);
    measure_period(per, hi);
    check("post_reset_period", 32'(per), 32'd2);
    check("post_reset_high", 32'(hi), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
